// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing defaults, derived totals and sync window constants
// Shared by the timing generator, its axis counters and the interface.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned H_SYNC_START = H_VISIBLE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-enable input and timing outputs of the VGA generator
// master = timing generator, slave = pixel consumer.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic       pix_en;
  coord_t     DrawX;
  coord_t     DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       sof;
  logic       eol;
  logic [7:0] frame_cnt;

  modport master (
    input  pix_en,
    output DrawX, DrawY, hs, vs, blank, sof, eol, frame_cnt
  );

  modport slave (
    output pix_en,
    input  DrawX, DrawY, hs, vs, blank, sof, eol, frame_cnt
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - 10-bit wrap counter with enable, terminal count and reset preset
// cnt_d is exported so the parent can decode outputs from the next-state value.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter coord_t LAST   = coord_t'(H_TOTAL - 1),
  parameter coord_t PRESET = coord_t'(H_TOTAL - 1)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t cnt_q,
  output coord_t cnt_d,
  output logic   tc
);

  always_comb begin
    // >= keeps any stray value inside the legal range on the next enabled tick
    tc    = (cnt_q >= LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tc ? '0 : cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= PRESET;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (counters, syncs, blank, pulses)
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by one enabled pixel tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input logic              vga_clk,
  input logic              reset_n,
  vga_timing_gen_if.master vif
);

  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t H_EOL    = coord_t'(H_VISIBLE - 1);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  coord_t     h_q, h_d, v_q, v_d;
  logic       h_tc, v_tc;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic       sof_q, sof_d, eol_q, eol_d;
  logic       started_q, started_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  vga_axis_cnt #(.LAST(H_LAST), .PRESET(H_LAST)) u_h_cnt (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .en    (vif.pix_en),
    .cnt_q (h_q),
    .cnt_d (h_d),
    .tc    (h_tc)
  );

  vga_axis_cnt #(.LAST(V_LAST), .PRESET(V_LAST)) u_v_cnt (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .en    (vif.pix_en & h_tc),
    .cnt_q (v_q),
    .cnt_d (v_d),
    .tc    (v_tc)
  );

  // Decoding the next-state counters keeps syncs/blank aligned with DrawX/DrawY
  always_comb begin
    hs_d        = ~in_window(h_d, HS_START, HS_END);
    vs_d        = ~in_window(v_d, VS_START, VS_END);
    blank_d     = (h_d < H_VIS) && (v_d < V_VIS);
    sof_d       = vif.pix_en & h_tc & v_tc;
    eol_d       = vif.pix_en && (h_d == H_EOL);
    started_d   = started_q | vif.pix_en;
    frame_cnt_d = frame_cnt_q;
    // The wrap out of the reset preset is not a completed frame
    if (sof_d && started_q) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      started_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      started_q   <= started_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;

  always_comb begin
    hs_dly_d = hs_dly_q;
    vs_dly_d = vs_dly_q;
    if (vif.pix_en) begin
      hs_dly_d = hs_q;
      vs_dly_d = vs_q;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
    end
  end

  assign vif.hs = hs_dly_q;
  assign vif.vs = vs_dly_q;
`else
  assign vif.hs = hs_q;
  assign vif.vs = vs_q;
`endif

  assign vif.DrawX     = h_q;
  assign vif.DrawY     = v_q;
  assign vif.blank     = blank_q;
  assign vif.sof       = sof_q;
  assign vif.eol       = eol_q;
  assign vif.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a shrunken raster
// Reference model pushes expected outputs per driven tick; tasks pop and compare.
module tb_vga_timing_gen;

  localparam int HV = 6, HF = 2, HSW = 2, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int HSS = HV + HF, HSE = HV + HF + HSW - 1;
  localparam int VSS = VV + VF, VSE = VV + VF + VSW - 1;
`ifdef VGA_SYNC_DELAY_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sof;
    logic       eol;
    logic [7:0] fc;
  } exp_t;

  logic vga_clk;
  logic reset_n;
  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vif     (vif)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_sof = -1;
  int   mx, my, mfc;
  bit   mstart, mhs, mvs, mhs_o, mvs_o;

  function automatic exp_t observe();
    exp_t o;
    o.x = vif.DrawX; o.y = vif.DrawY; o.hs = vif.hs; o.vs = vif.vs;
    o.blank = vif.blank; o.sof = vif.sof; o.eol = vif.eol; o.fc = vif.frame_cnt;
    return o;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.x = 10'(HT - 1); e.y = 10'(VT - 1); e.hs = 1'b1; e.vs = 1'b1;
    e.blank = 1'b0; e.sof = 1'b0; e.eol = 1'b0; e.fc = 8'd0;
    return e;
  endfunction

  task automatic model_reset();
    mx = HT - 1; my = VT - 1; mfc = 0; mstart = 0;
    mhs = 1; mvs = 1; mhs_o = 1; mvs_o = 1;
    sb.delete();
  endtask

  task automatic step(input bit en);
    exp_t e;
    bit   hs_new, vs_new;
    vif.pix_en = en;
    if (en) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    hs_new = !(mx >= HSS && mx <= HSE);
    vs_new = !(my >= VSS && my <= VSE);
    if (SD == 1) begin
      if (en) begin mhs_o = mhs; mvs_o = mvs; end
    end else begin
      mhs_o = hs_new; mvs_o = vs_new;
    end
    mhs = hs_new; mvs = vs_new;
    e.sof = en && mx == 0 && my == 0;
    if (e.sof && mstart) mfc = (mfc + 1) % 256;
    if (en) mstart = 1;
    e.x = 10'(mx); e.y = 10'(my); e.hs = mhs_o; e.vs = mvs_o;
    e.blank = (mx < HV) && (my < VV);
    e.eol = en && mx == HV - 1;
    e.fc = 8'(mfc);
    sb.push_back(e);
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    exp_t got;
    vif.pix_en = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    got = observe();
    n_checks++;
    if (got !== reset_exp()) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", got, reset_exp());
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk);
      #1;
      got = observe();
      n_checks++;
      if (got !== reset_exp()) begin
        n_fail++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, got, reset_exp());
      end
    end
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_first_edge();
    exp_t got, e;
    step(1'b1);
    got = observe();
    e = sb.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL first_edge_sb got=%h exp=%h", got, e);
    end
    n_checks++;
    if ({got.x, got.y, got.sof, got.blank, got.fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL first_edge_pos x=%0d y=%0d sof=%b blank=%b fc=%0d exp 0 0 1 1 0",
               got.x, got.y, got.sof, got.blank, got.fc);
    end
    last_sof = cyc;
  endtask

  task automatic test_line();
    exp_t got, e;
    int   hs_low = 0, hs_fall_x = -1, eol_n = 0, eol_prev = -1, eol_x = -1, eol_per = -1;
    logic hs_prev;
    hs_prev = vif.hs;
    for (int i = 0; i < 2 * HT + 1; i++) begin
      step(1'b1);
      got = observe();
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL line_sb cyc=%0d got=%h exp=%h", cyc, got, e);
      end
      if (i < HT && got.hs === 1'b0) hs_low++;
      if (hs_prev === 1'b1 && got.hs === 1'b0 && hs_fall_x < 0) hs_fall_x = int'(got.x);
      hs_prev = got.hs;
      if (got.eol === 1'b1) begin
        eol_n++;
        eol_x = int'(got.x);
        if (eol_prev >= 0) eol_per = cyc - eol_prev;
        eol_prev = cyc;
      end
    end
    n_checks++;
    if (hs_low != HSW) begin
      n_fail++;
      $display("FAIL hs_width got=%0d exp=%0d", hs_low, HSW);
    end
    n_checks++;
    if (hs_fall_x != HSS + SD) begin
      n_fail++;
      $display("FAIL hs_fall_x got=%0d exp=%0d", hs_fall_x, HSS + SD);
    end
    n_checks++;
    if (eol_x != HV - 1 || eol_n != 2) begin
      n_fail++;
      $display("FAIL eol_pos got x=%0d n=%0d exp x=%0d n=2", eol_x, eol_n, HV - 1);
    end
    n_checks++;
    if (eol_per != HT) begin
      n_fail++;
      $display("FAIL line_period got=%0d exp=%0d", eol_per, HT);
    end
  endtask

  task automatic test_frame();
    exp_t got, e;
    int   vs_low = 0, blank_n = 0, sof_n = 0, vs_fx = -1, vs_fy = -1;
    logic vs_prev;
    vs_prev = vif.vs;
    for (int i = 0; i < FT; i++) begin
      step(1'b1);
      got = observe();
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL frame_sb cyc=%0d got=%h exp=%h", cyc, got, e);
      end
      if (got.vs === 1'b0) vs_low++;
      if (got.blank === 1'b1) blank_n++;
      if (vs_prev === 1'b1 && got.vs === 1'b0 && vs_fx < 0) begin
        vs_fx = int'(got.x);
        vs_fy = int'(got.y);
      end
      vs_prev = got.vs;
      if (got.sof === 1'b1) begin
        sof_n++;
        n_checks++;
        if (cyc - last_sof != FT) begin
          n_fail++;
          $display("FAIL sof_period got=%0d exp=%0d", cyc - last_sof, FT);
        end
        last_sof = cyc;
      end
    end
    n_checks++;
    if (vs_low != VSW * HT) begin
      n_fail++;
      $display("FAIL vs_width got=%0d exp=%0d", vs_low, VSW * HT);
    end
    n_checks++;
    if (vs_fx != SD || vs_fy != VSS) begin
      n_fail++;
      $display("FAIL vs_fall got=(%0d,%0d) exp=(%0d,%0d)", vs_fx, vs_fy, SD, VSS);
    end
    n_checks++;
    if (blank_n != HV * VV || sof_n != 1) begin
      n_fail++;
      $display("FAIL frame_counts got blank=%0d sof=%0d exp blank=%0d sof=1", blank_n, sof_n, HV * VV);
    end
  endtask

  task automatic test_half_rate();
    exp_t got, e, prev;
    bit   wrapped = 0;
    int   sof_n = 0;
    last_sof = -1;
    prev = observe();
    for (int i = 0; i < 257 * FT * 2; i++) begin
      step(i % 2 == 0);
      got = observe();
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL half_sb cyc=%0d got=%h exp=%h", cyc, got, e);
      end
      if (i % 2 == 1) begin
        n_checks++;
        if ({got.x, got.y, got.hs, got.vs, got.blank, got.sof, got.eol, got.fc} !==
            {prev.x, prev.y, prev.hs, prev.vs, prev.blank, 2'b00, prev.fc}) begin
          n_fail++;
          $display("FAIL half_hold cyc=%0d got=%h prev=%h", cyc, got, prev);
        end
      end
      if (got.sof === 1'b1) begin
        sof_n++;
        if (last_sof >= 0) begin
          n_checks++;
          if (cyc - last_sof != 2 * FT) begin
            n_fail++;
            $display("FAIL half_sof_period got=%0d exp=%0d", cyc - last_sof, 2 * FT);
          end
        end
        last_sof = cyc;
      end
      if (prev.fc === 8'd255 && got.fc === 8'd0) wrapped = 1;
      prev = got;
    end
    n_checks++;
    if (!wrapped || sof_n < 256) begin
      n_fail++;
      $display("FAIL fc_wrap got wrapped=%0d sofs=%0d exp wrapped=1 sofs>=256", wrapped, sof_n);
    end
  endtask

  task automatic test_mid_reset();
    exp_t got, e;
    bit   hit = 0;
    for (int i = 0; i < 2 * FT && !hit; i++) begin
      step(1'b1);
      got = observe();
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL seek_sb cyc=%0d got=%h exp=%h", cyc, got, e);
      end
      if (got.x === 10'd3 && got.y === 10'd2) hit = 1;
    end
    n_checks++;
    if (!hit || vif.frame_cnt === 8'd0) begin
      n_fail++;
      $display("FAIL seek_target got hit=%0d fc=%0d exp hit=1 fc!=0", hit, vif.frame_cnt);
    end
    #3 reset_n = 1'b0;
    #1;
    got = observe();
    n_checks++;
    if (got !== reset_exp()) begin
      n_fail++;
      $display("FAIL mid_reset got=%h exp=%h", got, reset_exp());
    end
    model_reset();
    @(posedge vga_clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset_recovery();
    exp_t got, e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      got = observe();
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL recovery_sb i=%0d got=%h exp=%h", i, got, e);
      end
      if (i == 0) begin
        n_checks++;
        if ({got.x, got.y, got.sof, got.fc} !== {10'd0, 10'd0, 1'b1, 8'd0}) begin
          n_fail++;
          $display("FAIL recovery_first x=%0d y=%0d sof=%b fc=%0d exp 0 0 1 0",
                   got.x, got.y, got.sof, got.fc);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    vif.pix_en = 1'b0;
    test_reset();
    test_first_edge();
    test_line();
    test_frame();
    test_half_rate();
    test_mid_reset();
    test_reset_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
